// File: rtl/retire_trace_buffer_pkg.sv
// Shared ROB retire-trace constants.
// Holds the fixed retire-record field widths and the bit layout of one packed
// trace entry. From MSB to LSB the layout is {cycle, port, rd, oldrd, data}.
// The top derives its storage slicing from these helpers, so the layout is
// defined in one place only.
package retire_trace_buffer_pkg;

    // Width of the source-port index. It covers up to 4 retire ports.
    localparam int PORT_IDX_W = 2;

    // Width of the lost-entry counter and its saturation value.
    localparam int              DROP_W   = 16;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic int entry_w(input int cyc_w, input int rd_w, input int data_w);
        return cyc_w + PORT_IDX_W + 2 * rd_w + data_w;
    endfunction

    // Field offsets inside a packed entry. The data field sits at bit 0.
    function automatic int off_oldrd(input int data_w);
        return data_w;
    endfunction

    function automatic int off_rd(input int rd_w, input int data_w);
        return data_w + rd_w;
    endfunction

    function automatic int off_port(input int rd_w, input int data_w);
        return data_w + 2 * rd_w;
    endfunction

    function automatic int off_cycle(input int rd_w, input int data_w);
        return data_w + 2 * rd_w + PORT_IDX_W;
    endfunction

endpackage

// File: rtl/retire_compactor.sv
// Retire-port compactor.
// Packs the valid retire ports into consecutive tail slots in ascending port
// order. Each port's slot offset is the number of valid ports below it.
// With WRAP=0, a port is accepted only while its offset is still inside the
// free space, so the highest-numbered ports are the ones that drop.
// Ports:
//   ret_valid  in   per-port valid (already gated by enable)
//   space      in   free slots this cycle, including one freed by a read
//   slot_off   out  per-port offset from the tail pointer
//   accept     out  per-port write strobe
//   n          out  number of valid ports
//   n_acc      out  number of accepted ports
module retire_compactor #(
    parameter int NUM_PORTS = 2,
    parameter int WRAP      = 0,
    parameter int PTR_W     = 4,
    parameter int CNT_W     = 5
) (
    input  logic [NUM_PORTS-1:0]            ret_valid,
    input  logic [CNT_W-1:0]                space,
    output logic [NUM_PORTS-1:0][PTR_W-1:0] slot_off,
    output logic [NUM_PORTS-1:0]            accept,
    output logic [CNT_W-1:0]                n,
    output logic [CNT_W-1:0]                n_acc
);

    always_comb begin
        logic [CNT_W-1:0] tally;
        logic [CNT_W-1:0] tally_acc;
        // NOTE: blocking assignments are correct here; the running tally must be
        // visible to the next loop iteration within the same evaluation.
        tally     = '0;
        tally_acc = '0;
        slot_off  = '0;
        accept    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // The tally never exceeds NUM_PORTS-1 here, and that fits in PTR_W.
            slot_off[i] = PTR_W'(tally);
            if (ret_valid[i]) begin
                accept[i] = (WRAP != 0) || (tally < space);
                if (accept[i]) tally_acc = tally_acc + 1'b1;
                tally = tally + 1'b1;
            end
        end
        n     = tally;
        n_acc = tally_acc;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer.
// Captures up to NUM_PORTS retired instructions per cycle into a circular
// buffer. Each entry holds {cycle stamp, port, rd, oldrd, data}. The buffer
// is read first-word-fall-through from the head.
// WRAP=0 stops accepting entries when the buffer is full.
// WRAP=1 overwrites the oldest entries when the buffer is full.
// Any lost entry sets the sticky overflow flag and is counted in dropped.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   enable, clear            capture enable; synchronous flush pulse
//   ret_valid/rd/oldrd/data  per-port retire record, port 0 oldest
//   rd_ready                 consumer accepts the head entry
//   rd_valid, rd_cycle, rd_port, rd_rd, rd_oldrd, rd_data   head entry
//   count, overflow, dropped occupancy and loss status
//   cycle_count              free-running cycle counter
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 16,
    parameter int RD_W      = 6,
    parameter int DATA_W    = 32,
    parameter int CYC_W     = 32,
    parameter int WRAP      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [NUM_PORTS-1:0]        ret_valid,
    input  logic [NUM_PORTS*RD_W-1:0]   ret_rd,
    input  logic [NUM_PORTS*RD_W-1:0]   ret_oldrd,
    input  logic [NUM_PORTS*DATA_W-1:0] ret_data,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [CYC_W-1:0]            rd_cycle,
    output logic [1:0]                  rd_port,
    output logic [RD_W-1:0]             rd_rd,
    output logic [RD_W-1:0]             rd_oldrd,
    output logic [DATA_W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic [15:0]                 dropped,
    output logic [CYC_W-1:0]            cycle_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENT_W   = entry_w(CYC_W, RD_W, DATA_W);
    localparam int O_OLDRD = off_oldrd(DATA_W);
    localparam int O_RD    = off_rd(RD_W, DATA_W);
    localparam int O_PORT  = off_port(RD_W, DATA_W);
    localparam int O_CYC   = off_cycle(RD_W, DATA_W);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head_ent;

    logic [NUM_PORTS-1:0]            vld_g;
    logic [NUM_PORTS-1:0]            accept;
    logic [NUM_PORTS-1:0][PTR_W-1:0] slot_off;
    logic [CNT_W-1:0]                n;
    logic [CNT_W-1:0]                n_acc;
    logic                            rd_fire;
    logic [CNT_W-1:0]                space;
    logic [CNT_W-1:0]                head_adv;
    logic [CNT_W-1:0]                tail_adv;
    logic [CNT_W-1:0]                count_nxt;
    logic [CNT_W-1:0]                lost;
    logic [DROP_W:0]                 drop_sum;

    assign vld_g   = enable ? ret_valid : '0;
    assign rd_fire = rd_valid & rd_ready;
    // The slot being read this cycle is free for this cycle's writes.
    assign space   = CNT_W'(DEPTH) - count + CNT_W'(rd_fire);

    retire_compactor #(
        .NUM_PORTS (NUM_PORTS),
        .WRAP      (WRAP),
        .PTR_W     (PTR_W),
        .CNT_W     (CNT_W)
    ) u_compactor (
        .ret_valid (vld_g),
        .space     (space),
        .slot_off  (slot_off),
        .accept    (accept),
        .n         (n),
        .n_acc     (n_acc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is
        // inferred whichever branch is taken.
        head_adv  = CNT_W'(rd_fire);
        tail_adv  = n_acc;
        lost      = n - n_acc;
        count_nxt = count + n_acc - CNT_W'(rd_fire);
        if (WRAP != 0) begin
            // Every valid port is written. Any excess over the free space
            // pushes the head past the oldest entries.
            lost      = (n > space) ? n - space : '0;
            tail_adv  = n;
            head_adv  = CNT_W'(rd_fire) + lost;
            count_nxt = count - CNT_W'(rd_fire) + n - lost;
        end
    end

    assign drop_sum = {1'b0, dropped} + (DROP_W + 1)'(lost);

    // Control state
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            dropped     <= '0;
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (clear) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                overflow <= 1'b0;
                dropped  <= '0;
            end else begin
                head  <= head + PTR_W'(head_adv);
                tail  <= tail + PTR_W'(tail_adv);
                count <= count_nxt;
                if (lost != '0) begin
                    overflow <= 1'b1;
                    dropped  <= drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];
                end
            end
        end
    end

    // Entry storage, with NUM_PORTS write ports.
    // NOTE: the storage array is deliberately not reset. count and the
    // pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept[i]) begin
                    mem[tail + slot_off[i]] <= {cycle_count, PORT_IDX_W'(i),
                                                ret_rd[i*RD_W +: RD_W],
                                                ret_oldrd[i*RD_W +: RD_W],
                                                ret_data[i*DATA_W +: DATA_W]};
                end
            end
        end
    end

    // First-word-fall-through read port.
    assign head_ent = mem[head];
    assign rd_valid = (count != '0);
    assign rd_cycle = head_ent[O_CYC +: CYC_W];
    assign rd_port  = head_ent[O_PORT +: PORT_IDX_W];
    assign rd_rd    = head_ent[O_RD +: RD_W];
    assign rd_oldrd = head_ent[O_OLDRD +: RD_W];
    assign rd_data  = head_ent[0 +: DATA_W];

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Testbench for retire_trace_buffer.
// Two instances, one with WRAP=0 and one with WRAP=1, share the same stimulus.
// For each instance, a queue-based reference model predicts the buffer
// contents. Each cycle, the driver pushes the expected status, and pushes the
// expected head entry whenever a read handshake is due. A monitor on the
// falling edge pops these records and compares them with the DUT.
module tb_retire_trace_buffer;

    localparam int NP     = 2;
    localparam int DEPTH  = 16;
    localparam int RD_W   = 6;
    localparam int DATA_W = 32;
    localparam int CYC_W  = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic [CYC_W-1:0]  cyc;
        logic [1:0]        port;
        logic [RD_W-1:0]   rd;
        logic [RD_W-1:0]   oldrd;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        int               count;
        bit               ovf;
        int               dropped;
        logic [CYC_W-1:0] cyc;
    } stat_t;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic                   rst, enable, clear, rd_ready;
    logic [NP-1:0]          ret_valid;
    logic [NP*RD_W-1:0]     ret_rd, ret_oldrd;
    logic [NP*DATA_W-1:0]   ret_data;

    logic                   rd_valid    [2];
    logic [CYC_W-1:0]       rd_cycle    [2];
    logic [1:0]             rd_port     [2];
    logic [RD_W-1:0]        rd_rd       [2];
    logic [RD_W-1:0]        rd_oldrd    [2];
    logic [DATA_W-1:0]      rd_data     [2];
    logic [CNT_W-1:0]       count       [2];
    logic                   overflow    [2];
    logic [15:0]            dropped     [2];
    logic [CYC_W-1:0]       cycle_count [2];

    retire_trace_buffer #(.NUM_PORTS(NP), .DEPTH(DEPTH), .RD_W(RD_W), .DATA_W(DATA_W),
                          .CYC_W(CYC_W), .WRAP(0)) dut_stop (
        .clk(tb_clk), .rst(rst), .enable(enable), .clear(clear),
        .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_oldrd(ret_oldrd), .ret_data(ret_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid[0]), .rd_cycle(rd_cycle[0]),
        .rd_port(rd_port[0]), .rd_rd(rd_rd[0]), .rd_oldrd(rd_oldrd[0]), .rd_data(rd_data[0]),
        .count(count[0]), .overflow(overflow[0]), .dropped(dropped[0]),
        .cycle_count(cycle_count[0])
    );

    retire_trace_buffer #(.NUM_PORTS(NP), .DEPTH(DEPTH), .RD_W(RD_W), .DATA_W(DATA_W),
                          .CYC_W(CYC_W), .WRAP(1)) dut_wrap (
        .clk(tb_clk), .rst(rst), .enable(enable), .clear(clear),
        .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_oldrd(ret_oldrd), .ret_data(ret_data),
        .rd_ready(rd_ready), .rd_valid(rd_valid[1]), .rd_cycle(rd_cycle[1]),
        .rd_port(rd_port[1]), .rd_rd(rd_rd[1]), .rd_oldrd(rd_oldrd[1]), .rd_data(rd_data[1]),
        .count(count[1]), .overflow(overflow[1]), .dropped(dropped[1]),
        .cycle_count(cycle_count[1])
    );

    // Reference model and scoreboard queues; index 0 is WRAP=0, index 1 is WRAP=1.
    ent_t             mq [2][$];
    stat_t            sq [2][$];
    ent_t             rq [2][$];
    bit               m_ovf  [2];
    int               m_drop [2];
    logic [CYC_W-1:0] m_cyc;
    bit               active;
    int               vectors;
    int               miscompares;

    task automatic check(input string name, input int k, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (wrap=%0d) t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Model one clock edge for both instances, using the current inputs.
    task automatic step();
        ent_t e;
        int   lost;
        for (int k = 0; k < 2; k++) begin
            sq[k].push_back('{count: mq[k].size(), ovf: m_ovf[k], dropped: m_drop[k], cyc: m_cyc});
            if (rd_ready && mq[k].size() != 0) rq[k].push_back(mq[k][0]);
            if (rst || clear) begin
                mq[k].delete();
                m_ovf[k]  = 1'b0;
                m_drop[k] = 0;
            end else begin
                if (rd_ready && mq[k].size() != 0) void'(mq[k].pop_front());
                lost = 0;
                if (enable) begin
                    for (int p = 0; p < NP; p++) begin
                        if (ret_valid[p]) begin
                            e.cyc   = m_cyc;
                            e.port  = 2'(p);
                            e.rd    = ret_rd[p*RD_W +: RD_W];
                            e.oldrd = ret_oldrd[p*RD_W +: RD_W];
                            e.data  = ret_data[p*DATA_W +: DATA_W];
                            if (k == 1 || mq[k].size() < DEPTH) mq[k].push_back(e);
                            else lost++;
                            if (mq[k].size() > DEPTH) begin
                                void'(mq[k].pop_front());
                                lost++;
                            end
                        end
                    end
                end
                if (lost > 0) begin
                    m_ovf[k]  = 1'b1;
                    m_drop[k] = (m_drop[k] + lost > 65535) ? 65535 : m_drop[k] + lost;
                end
            end
        end
        m_cyc  = rst ? '0 : m_cyc + 1'b1;
        active = 1'b1;
        @(posedge tb_clk);
        #1;
    endtask

    task automatic set_ports(input logic [1:0] v, input int rd0, input int rd1,
                             input int d0, input int d1);
        logic [RD_W-1:0] r0, r1;
        r0        = RD_W'(rd0);
        r1        = RD_W'(rd1);
        ret_valid = v;
        ret_rd    = {r1, r0};
        ret_oldrd = (NP*RD_W)'($urandom);
        ret_data  = {32'(d1), 32'(d0)};
    endtask

    task automatic rand_ports();
        ret_valid = NP'($urandom);
        ret_rd    = (NP*RD_W)'($urandom);
        ret_oldrd = (NP*RD_W)'($urandom);
        ret_data  = {$urandom, $urandom};
    endtask

    // Monitor: compares the DUT with the popped expectations on each falling edge.
    initial begin
        stat_t s;
        ent_t  e;
        forever begin
            @(negedge tb_clk);
            if (active) begin
                for (int k = 0; k < 2; k++) begin
                    if (sq[k].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL status_queue (wrap=%0d): no expected status, got count %0d", k, count[k]);
                    end else begin
                        s = sq[k].pop_front();
                        check("count",       k, 64'(count[k]),       64'(s.count));
                        check("rd_valid",    k, 64'(rd_valid[k]),    64'(s.count != 0));
                        check("overflow",    k, 64'(overflow[k]),    64'(s.ovf));
                        check("dropped",     k, 64'(dropped[k]),     64'(s.dropped));
                        check("cycle_count", k, 64'(cycle_count[k]), 64'(s.cyc));
                    end
                    if (rd_valid[k] === 1'b1 && rd_ready) begin
                        if (rq[k].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL read_queue (wrap=%0d): unexpected read, got rd_rd %0h", k, rd_rd[k]);
                        end else begin
                            e = rq[k].pop_front();
                            check("rd_cycle", k, 64'(rd_cycle[k]), 64'(e.cyc));
                            check("rd_port",  k, 64'(rd_port[k]),  64'(e.port));
                            check("rd_rd",    k, 64'(rd_rd[k]),    64'(e.rd));
                            check("rd_oldrd", k, 64'(rd_oldrd[k]), 64'(e.oldrd));
                            check("rd_data",  k, 64'(rd_data[k]),  64'(e.data));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int ready_pct;
        vectors     = 0;
        miscompares = 0;
        active      = 1'b0;
        m_cyc       = '0;
        m_ovf       = '{1'b0, 1'b0};
        m_drop      = '{0, 0};
        rst         = 1'b1;
        clear       = 1'b0;
        enable      = 1'b0;
        rd_ready    = 1'b0;
        ret_valid   = '0;
        ret_rd      = '0;
        ret_oldrd   = '0;
        ret_data    = '0;
        repeat (2) @(posedge tb_clk);
        #1;
        step();                       // one more reset cycle, with status checked
        rst    = 1'b0;
        enable = 1'b1;

        // Cycles 0..2 idle, then both ports retire on cycle 3.
        repeat (3) step();
        set_ports(2'b11, 5, 7, 10, 20);
        step();
        set_ports(2'b00, 0, 0, 0, 0);
        step();                       // count=2, head not yet read
        rd_ready = 1'b1;
        repeat (2) step();            // reads rd=5/data=10/port0/cyc3, then rd=7
        rd_ready = 1'b0;

        // A lone port-1 retire lands in the first free slot.
        set_ports(2'b10, 0, 9, 0, 99);
        step();
        set_ports(2'b00, 0, 0, 0, 0);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        step();

        // Fill to 15, then push two more: full-buffer drop versus overwrite.
        repeat (7) begin
            set_ports(2'b11, $urandom, $urandom, $urandom, $urandom);
            step();
        end
        set_ports(2'b01, $urandom, 0, $urandom, 0);
        step();
        set_ports(2'b11, 1, 2, 3, 4);
        step();                       // 15 held, no read
        rd_ready = 1'b1;
        set_ports(2'b11, 11, 12, 13, 14);
        step();                       // full with a read
        rd_ready = 1'b0;
        set_ports(2'b11, 21, 22, 23, 24);
        step();                       // full, no read
        set_ports(2'b00, 0, 0, 0, 0);
        step();
        rd_ready = 1'b1;
        repeat (18) step();           // drain and check contents

        // Clear with same-cycle retires and a read, then a mid-stream reset.
        rd_ready = 1'b0;
        set_ports(2'b11, 1, 2, 3, 4);
        repeat (2) step();
        set_ports(2'b01, 5, 0, 6, 0);
        step();                       // count=5
        set_ports(2'b11, 30, 31, 32, 33);
        rd_ready = 1'b1;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        set_ports(2'b00, 0, 0, 0, 0);
        rd_ready = 1'b0;
        step();
        set_ports(2'b11, 40, 41, 42, 43);
        repeat (3) step();
        rd_ready = 1'b1;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        rd_ready = 1'b0;
        set_ports(2'b11, 50, 51, 52, 53);
        step();                       // captured with cycle stamp 0
        set_ports(2'b00, 0, 0, 0, 0);
        rd_ready = 1'b1;
        repeat (3) step();

        // Retires are ignored while enable is low.
        enable = 1'b0;
        set_ports(2'b11, 60, 61, 62, 63);
        repeat (2) step();
        enable = 1'b1;

        // Random phase; the read probability varies to reach both full and empty.
        ready_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) ready_pct = $urandom_range(0, 100);
            rand_ports();
            enable   = ($urandom_range(0, 9) != 0);
            rd_ready = ($urandom_range(0, 99) < ready_pct);
            clear    = ($urandom_range(0, 199) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            step();
        end
        rst       = 1'b0;
        clear     = 1'b0;
        ret_valid = '0;
        rd_ready  = 1'b1;
        repeat (DEPTH + 2) step();
        active = 1'b0;

        for (int k = 0; k < 2; k++) begin
            check("reads_pending", k, 64'(rq[k].size()), 64'(0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of retire ports captured per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 16, trace entries (power of 2, >= NUM_PORTS).
REQ-003 SHALL have parameters RD_W (default 6), physical register tag width, and DATA_W (default 32), result width.
REQ-004 SHALL have parameter CYC_W, default 32, cycle-stamp width.
REQ-005 SHALL have parameter WRAP, default 0; 0 = stop-when-full, 1 = overwrite-oldest.
REQ-006 SHALL have ports:
 clk  in  1  single clock, rising edge.
 rst  in  1  synchronous, active-high reset.
 enable  in  1  capture enable.
 clear  in  1  synchronous buffer flush pulse.
 ret_valid  in  NUM_PORTS  per-port retire valid; port 0 is oldest.
 ret_rd  in  NUM_PORTS*RD_W  per-port destination tag.
 ret_oldrd  in  NUM_PORTS*RD_W  per-port freed old tag.
 ret_data  in  NUM_PORTS*DATA_W  per-port result.
 rd_ready  in  1  consumer accepts head entry.
 rd_valid  out  1  head entry present.
 rd_cycle  out  CYC_W  head cycle stamp.
 rd_port  out  2  head source port.
 rd_rd / rd_oldrd  out  RD_W  head tags.
 rd_data  out  DATA_W  head result.
 count  out  log2(DEPTH)+1  occupied entries.
 overflow  out  1  sticky loss flag.
 dropped  out  16  lost-entry count, saturating at 0xFFFF.
 cycle_count  out  CYC_W  free-running cycle counter.

Function
REQ-007 cycle_count SHALL increment by 1 every cycle, wrap modulo 2^CYC_W, and be unaffected by enable and clear.
REQ-008 Each captured entry SHALL hold {cycle_count value of capture cycle, port index, rd, oldrd, data}.
REQ-009 Per cycle: n = valid ports when enable=1 (else 0); r = rd_valid & rd_ready; space = DEPTH - count + r.
REQ-010 Valid ports SHALL be packed into consecutive slots at the tail in ascending port order, with no gaps for invalid ports.
REQ-011 WRAP=0: accept a = min(n, space), drop the highest-numbered n-a valid ports; tail += a; head += r.
REQ-012 WRAP=1: accept all n; o = max(0, n - space) oldest entries overwritten; head += r + o; count_next = min(DEPTH, count - r + n).
REQ-013 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-014 Read SHALL be first-word-fall-through: rd_* reflect the head combinationally; rd_valid = (count != 0); a write does not appear at rd_* before the next cycle.
REQ-015 Simultaneous read and write SHALL both take effect; count_next = count + accepted - r (WRAP=0).
REQ-016 Any drop (REQ-011) or overwrite (REQ-012) SHALL set overflow and add the lost number to dropped, saturating.
REQ-017 clear=1 SHALL empty the buffer, clear overflow and dropped; same-cycle retires and reads are discarded and not counted.
REQ-018 rd_* SHALL be don't-care when rd_valid=0; rd_ready with rd_valid=0 SHALL have no effect.

Reset
REQ-019 On rst=1 at a clock edge: head=tail=0, count=0, rd_valid=0, overflow=0, dropped=0, cycle_count=0.
REQ-020 rst SHALL take priority over clear, retires and reads in the same cycle; entry storage is not reset.
REQ-021 Reset mid-stream SHALL discard all buffered entries; the first capture after reset carries cycle stamp 0 if retired in the first post-reset cycle.

Structure
REQ-022 Retire-record field widths and trace-entry field offsets SHALL be defined in the shared ROB constants include, alongside the existing retire record definitions.
REQ-023 Slot-offset/popcount logic SHALL be a sub-module retire_compactor (inputs ret_valid, space; outputs per-port slot offset, accept mask, n).
REQ-024 Storage SHALL be a register array of DEPTH entries with NUM_PORTS write ports and one read port.

Verification
REQ-025 Reset, then ret_valid=2'b11 with rd=5/7, data=10/20 on cycle 3 -> next cycle count=2, rd_rd=5, rd_data=10, rd_port=0, rd_cycle=3.
REQ-026 ret_valid=2'b10 only (port 1, rd=9) -> single entry in slot 0, rd_port=1, count=1.
REQ-027 WRAP=0, DEPTH=16, 15 entries held, ret_valid=2'b11, rd_ready=0 -> port 0 stored, count=16, overflow=1, dropped=1.
REQ-028 WRAP=0, count=16, ret_valid=2'b11, rd_ready=1 -> one read, port 0 accepted, port 1 dropped, count stays 16, dropped+=1.
REQ-029 WRAP=1, count=16, ret_valid=2'b11, rd_ready=0 -> two oldest overwritten, count=16, head advances 2, dropped=2.
REQ-030 clear=1 with ret_valid=2'b11 and count=5, then rst=1 mid-stream -> after clear count=0, overflow=0, dropped=0, cycle_count continues; after reset all outputs per REQ-019 and cycle_count=0.
